// File: rtl/josh_pkg.sv
// Shared definitions for the J.O.S.H. Jump engine, screen updater and wall generator.
package josh_pkg;

  typedef enum logic [1:0] {
    S_MENU = 2'd0,
    S_ARM  = 2'd1,
    S_PLAY = 2'd2,
    S_DEAD = 2'd3
  } state_e;

  typedef enum logic {
    GRAV_DOWN = 1'b0,
    GRAV_UP   = 1'b1
  } grav_e;

  localparam int unsigned JOSH_ROWS     = 120;
  localparam int unsigned JOSH_DUDE_H   = 6;
  localparam int unsigned JOSH_TICK_DIV = 833333;

endpackage

// File: rtl/josh_tick_divider.sv
// Rate counter: counts 0..DIV-1 while en is high and pulses wrap for one cycle
// each time the count returns to 0.
module josh_tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic wrap
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (en) begin
      if (count == CW'(DIV - 1)) begin
        count <= '0;
        wrap  <= 1'b1;
      end else begin
        count <= count + CW'(1);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/josh_player_engine.sv
// Game-state FSM and player physics for J.O.S.H. Jump.
// Optional high-score register enabled by defining JOSH_HISCORE_EN.
module josh_player_engine
  import josh_pkg::*;
#(
  parameter int unsigned ROWS       = JOSH_ROWS,
  parameter int unsigned DUDE_H     = JOSH_DUDE_H,
  parameter int unsigned Y_START    = 20,
  parameter int unsigned TICK_DIV   = JOSH_TICK_DIV,
  parameter int unsigned DEAD_TICKS = 90,
  parameter int unsigned SCORE_W    = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     go,
  input  logic                     grav,
  input  logic [ROWS-1:0]          wall_here,
  input  logic [ROWS-1:0]          wall_ahead,
  output logic                     tick,
  output logic                     in_game,
  output logic                     endgame,
  output logic [$clog2(ROWS)-1:0]  player_y,
  output logic [SCORE_W-1:0]       score,
  output logic [1:0]               state
`ifdef JOSH_HISCORE_EN
  ,
  output logic [SCORE_W-1:0]       hiscore
`endif
);

  localparam int unsigned RW = $clog2(ROWS) + 1;
  localparam int unsigned DW = $clog2(DEAD_TICKS) + 1;
  localparam logic [RW-1:0] ONE = RW'(1);
  localparam logic [RW-1:0] DH  = RW'(DUDE_H);
  localparam logic [RW-1:0] TOP = RW'(ROWS);
  localparam logic [RW-1:0] Y0  = RW'(Y_START);
  localparam logic [ROWS-1:0] WIN = {{(ROWS-DUDE_H){1'b0}}, {DUDE_H{1'b1}}};

  state_e          state_q;
  grav_e           grav_lat;
  logic [RW-1:0]   py;
  logic [DW-1:0]   dead_cnt;
  logic            go_r, grav_r;
  logic [ROWS-1:0] here_r, ahead_r;

  logic [ROWS-1:0]    here_dn, here_up;
  logic               ahead_hit, solid, crush;
  logic [RW-1:0]      py_next;
  logic [SCORE_W-1:0] score_inc, final_score;

  josh_tick_divider #(.DIV(TICK_DIV)) u_div (
    .clk    (clk),
    .resetn (resetn),
    .en     (1'b1),
    .wrap   (tick)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      go_r    <= 1'b0;
      grav_r  <= 1'b0;
      here_r  <= '0;
      ahead_r <= '0;
    end else begin
      go_r    <= go;
      grav_r  <= grav;
      here_r  <= wall_here;
      ahead_r <= wall_ahead;
    end
  end

  // Support/crush rows are fetched by shifting so the row index never needs
  // to fit the vector's select width; out-of-range rows are covered by the
  // floor/ceiling terms.
  always_comb begin
    here_dn   = here_r >> (py - ONE);
    here_up   = here_r >> (py + DH);
    ahead_hit = |(ahead_r & (WIN << py));
    if (grav_lat == GRAV_DOWN) solid = (py == '0) || here_dn[0];
    else                       solid = ((py + DH) == TOP) || here_up[0];
    py_next = py;
    if (!solid) py_next = (grav_lat == GRAV_UP) ? py + ONE : py - ONE;
    crush       = |(here_r & (WIN << py_next));
    score_inc   = (&score) ? score : score + SCORE_W'(1);
    final_score = ahead_hit ? score : score_inc;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_MENU;
      grav_lat <= GRAV_DOWN;
      py       <= Y0;
      score    <= '0;
      in_game  <= 1'b0;
      endgame  <= 1'b0;
      dead_cnt <= '0;
`ifdef JOSH_HISCORE_EN
      hiscore  <= '0;
`endif
    end else begin
      endgame <= 1'b0;
      unique case (state_q)
        S_MENU: if (go_r) state_q <= S_ARM;
        S_ARM: begin
          if (!go_r) begin
            state_q  <= S_PLAY;
            in_game  <= 1'b1;
            score    <= '0;
            py       <= Y0;
            grav_lat <= grav_e'(grav_r);
          end
        end
        S_PLAY: begin
          if (tick) begin
            if (!ahead_hit) begin
              py    <= py_next;
              score <= score_inc;
              if (solid) grav_lat <= grav_e'(grav_r);
            end
            if (ahead_hit || crush) begin
              state_q  <= S_DEAD;
              in_game  <= 1'b0;
              endgame  <= 1'b1;
              dead_cnt <= '0;
`ifdef JOSH_HISCORE_EN
              if (final_score > hiscore) hiscore <= final_score;
`endif
            end
          end
        end
        S_DEAD: begin
          if (tick) begin
            if (dead_cnt == DW'(DEAD_TICKS - 1)) state_q <= S_MENU;
            else dead_cnt <= dead_cnt + DW'(1);
          end
        end
      endcase
    end
  end

  assign state    = state_q;
  assign player_y = py[RW-2:0];

endmodule

// File: tb/tb_josh_player_engine.sv
// Self-checking bench for josh_player_engine; hiscore checks follow JOSH_HISCORE_EN.
module tb_josh_player_engine;

  localparam int ROWS = 120;
  localparam int DH   = 6;
  localparam int YS   = 20;
  localparam int TD   = 4;
  localparam int DT   = 90;
  localparam int SW   = 8;
  localparam int SMAX = (1 << SW) - 1;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            go = 1'b0;
  logic            grav = 1'b0;
  logic [ROWS-1:0] wall_here = '0;
  logic [ROWS-1:0] wall_ahead = '0;
  logic            tick, in_game, endgame;
  logic [6:0]      player_y;
  logic [SW-1:0]   score;
  logic [1:0]      state;
`ifdef JOSH_HISCORE_EN
  logic [SW-1:0]   hiscore;
`endif

  josh_player_engine #(
    .ROWS(ROWS), .DUDE_H(DH), .Y_START(YS), .TICK_DIV(TD),
    .DEAD_TICKS(DT), .SCORE_W(SW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .go         (go),
    .grav       (grav),
    .wall_here  (wall_here),
    .wall_ahead (wall_ahead),
    .tick       (tick),
    .in_game    (in_game),
    .endgame    (endgame),
    .player_y   (player_y),
    .score      (score),
    .state      (state)
`ifdef JOSH_HISCORE_EN
    ,
    .hiscore    (hiscore)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int k = 0;
  // reference model: 0 menu, 1 arm, 2 play, 3 dead
  int m_state, m_y, m_g, m_score, m_dead, m_hi;
  int m_end;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic bit window(input logic [ROWS-1:0] v, input int y);
    for (int i = 0; i < DH; i++)
      if (y + i < ROWS && v[y+i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    check("state", state, m_state);
    check("in_game", in_game, (m_state == 2));
    check("endgame", endgame, m_end);
    check("player_y", player_y, m_y);
    check("score", score, m_score);
`ifdef JOSH_HISCORE_EN
    check("hiscore", hiscore, m_hi);
`endif
  endtask

  task automatic die();
    m_state = 3;
    m_end   = 1;
    m_dead  = 0;
    if (m_score > m_hi) m_hi = m_score;
  endtask

  task automatic model_tick();
    bit solid;
    m_end = 0;
    if (m_state == 2) begin
      if (window(wall_ahead, m_y)) die();
      else begin
        if (m_g == 0) solid = (m_y == 0) ? 1'b1 : wall_here[m_y-1];
        else          solid = (m_y + DH == ROWS) ? 1'b1 : wall_here[m_y+DH];
        if (!solid) m_y = (m_g == 1) ? m_y + 1 : m_y - 1;
        else        m_g = grav;
        m_score = (m_score == SMAX) ? SMAX : m_score + 1;
        if (window(wall_here, m_y)) die();
      end
    end else if (m_state == 3) begin
      m_dead++;
      if (m_dead == DT) m_state = 0;
    end
  endtask

  // Advance to just after the next edge that consumes a tick, checking the
  // strobe and that the player does not move before that edge.
  task automatic run_tick();
    int prev_y;
    prev_y = m_y;
    do begin
      cyc();
      if (k % TD != 1) begin
        check("endgame_idle", endgame, 0);
        check("tick", tick, (k % TD == 0));
      end
      if (k % TD == 0) check("hold_y", player_y, prev_y);
    end while (k % TD != 1);
    model_tick();
    check_outputs();
  endtask

  task automatic start_game();
    go = 1'b1;
    cyc(); check("menu_wait", state, 0); check("tick_s", tick, (k % TD == 0));
    cyc(); check("arm", state, 1);      check("tick_s", tick, (k % TD == 0));
    cyc(); go = 1'b0;                    check("tick_s", tick, (k % TD == 0));
    cyc(); check("arm_hold", state, 1); check("tick_s", tick, (k % TD == 0));
    cyc();
    m_state = 2; m_y = YS; m_score = 0; m_g = grav; m_end = 0;
    check_outputs();
  endtask

  task automatic run_dead();
    for (int i = 0; i < DT; i++) begin
      go = (i < DT - 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_tick();
    end
    check("dead_to_menu", state, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int idx;
    m_state = 0; m_y = YS; m_score = 0; m_g = 0; m_hi = 0; m_end = 0; m_dead = 0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    check("tick_reset", tick, 0);
    @(negedge clk);
    resetn = 1'b1;
    k = 0;

    // game A: stand on row 19, survive 50 ticks, hit a wall ahead
    wall_here = '0; wall_here[YS-1] = 1'b1; grav = 1'b0;
    start_game();
    repeat (50) run_tick();
    wall_ahead[YS+2] = 1'b1;
    run_tick();
    check("collide_score", score, 50);
    check("collide_y", player_y, YS);
    wall_ahead = '0;
    run_dead();

    // game A2: shorter game must not lower the high score
    start_game();
    repeat (30) run_tick();
    wall_ahead[YS] = 1'b1;
    run_tick();
    wall_ahead = '0;
    run_dead();
`ifdef JOSH_HISCORE_EN
    check("hiscore_keep", hiscore, 50);
`endif

    // game B: fall, flip up, fly with ignored mid-air flips, fall, land, saturate
    wall_here = '0; wall_ahead = '0; grav = 1'b0;
    start_game();
    repeat (20) run_tick();
    check("fell_to_floor", player_y, 0);
    repeat (5) run_tick();
    grav = 1'b1;
    run_tick();
    run_tick();
    for (int i = 0; i < 130 && m_y < ROWS - DH; i++) begin
      grav = (m_y > 5 && m_y < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
      run_tick();
    end
    check("ceiling", player_y, ROWS - DH);
    repeat (3) run_tick();
    grav = 1'b0;
    for (int i = 0; i < 200 && m_y != 15; i++) run_tick();
    wall_here[9] = 1'b1;
    repeat (10) run_tick();
    check("landed", player_y, 10);
    repeat (20) run_tick();
    check("saturate", score, SMAX);
    wall_ahead[m_y] = 1'b1;
    run_tick();
    wall_ahead = '0;
    run_dead();

    // randomised games
    for (int g = 0; g < 4; g++) begin
      wall_here = '0; wall_ahead = '0; grav = 1'($urandom_range(0, 1));
      start_game();
      for (int t = 0; t < 40 && m_state == 2; t++) begin
        go = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) grav = ~grav;
        wall_here = '0;
        wall_ahead = '0;
        if ($urandom_range(0, 2) == 0) begin
          idx = $urandom_range(0, ROWS - 1);
          wall_here[idx] = 1'b1;
        end
        if ($urandom_range(0, 9) == 0) begin
          idx = $urandom_range(0, ROWS - 1);
          wall_ahead[idx] = 1'b1;
        end
        run_tick();
      end
      go = 1'b0;
      wall_here = '0;
      wall_ahead = '0;
      if (m_state == 2) begin
        wall_ahead[m_y] = 1'b1;
        run_tick();
        wall_ahead = '0;
      end
      run_dead();
    end

    // reset in the middle of a game aborts without an endgame pulse
    wall_here = '0; wall_ahead = '0; grav = 1'b0;
    start_game();
    repeat (3) run_tick();
    resetn = 1'b0;
    cyc();
    m_state = 0; m_y = YS; m_score = 0; m_hi = 0; m_end = 0;
    check_outputs();
    check("tick_abort", tick, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/josh_player_engine.md
Name: josh_player_engine

Overview:
- Parametrised game-state and player-physics engine for J.O.S.H. Jump; successor to the fixed menu/game controller and player datapath.
- Owns the MENU/PLAY/DEAD state machine, a game-tick divider, vertical player motion under switchable gravity, wall collision and a survival score.
- Sits between board I/O (go key, gravity switch) and the wall generator / screen updater.
- Consumes per-column wall occupancy; produces player position, scroll tick and game status.

Parameters:
- ROWS, 120: playfield height in pixels; row 0 is the bottom.
- DUDE_H, 6: player height in rows.
- Y_START, 20: player bottom row on game start.
- TICK_DIV, 833333: clk cycles per game tick (60 Hz at 50 MHz); must be >= 2.
- DEAD_TICKS, 90: ticks spent in DEAD before returning to MENU.
- SCORE_W, 16: score width.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous reset, active-low
- go  in  1  start request, level; active-high, already inverted from KEY
- grav  in  1  gravity select: 0 = down, 1 = up
- wall_here  in  ROWS  occupancy of the column under the player; bit r = row r solid
- wall_ahead  in  ROWS  occupancy of the column one pixel right of the player
- tick  out  1  one-cycle game-tick strobe; wall generator scrolls on it
- in_game  out  1  high in PLAY
- endgame  out  1  one-cycle pulse on PLAY->DEAD
- player_y  out  clog2(ROWS)  player bottom row
- score  out  SCORE_W  ticks survived in the current or last game
- state  out  2  encoded FSM state, for the display

Behaviour:
- Reset: all outputs 0 except player_y = Y_START; state = MENU; divider count = 0. Reset mid-game aborts immediately, with no endgame pulse.
- Tick: the divider counts 0..TICK_DIV-1 in every state and pulses tick when the count wraps to 0. All physics updates use the registered inputs and take effect on the cycle after tick, so tick-to-player_y latency is 1 cycle.
- FSM states:
  - MENU: on go=1 -> ARM.
  - ARM: waits for go=0 (release), then -> PLAY. On entry to PLAY: score = 0, player_y = Y_START, grav_lat = grav.
  - PLAY: evaluated per tick, see below.
  - DEAD: counts DEAD_TICKS ticks, then -> MENU. go is ignored in DEAD.
- Per tick in PLAY, in this order:
  - a. Horizontal collision: if any of wall_ahead[player_y .. player_y+DUDE_H-1] is set -> DEAD. In the same cycle: endgame = 1, player_y is frozen and score is not incremented.
  - b. Support row: for grav_lat=0, row = player_y-1, treated as solid when player_y = 0. For grav_lat=1, row = player_y+DUDE_H, treated as solid when player_y+DUDE_H = ROWS. The support bit is read from wall_here.
  - c. Motion: if the support row is not solid, player_y moves 1 row toward gravity; otherwise it is held (grounded).
  - d. Gravity flip: grav_lat takes the value of grav only when grounded this tick. Flips in mid-air are ignored until landing.
  - e. score increments by 1 and saturates at all-ones.
- Crush: if, after motion, any of wall_here[player_y .. player_y+DUDE_H-1] is set -> DEAD on the same tick.
- Simultaneous events: collision wins over motion and score. go pulses during PLAY are ignored.
- Widths: all row arithmetic uses clog2(ROWS)+1 bits so that comparisons do not wrap. player_y never leaves 0..ROWS-DUDE_H.

Optional Feature:
- Macro: JOSH_HISCORE_EN.
- When defined:
  - adds output hiscore [SCORE_W-1:0], reset to 0;
  - on each PLAY->DEAD transition, hiscore = max(hiscore, final score);
  - hiscore is cleared only by resetn.
- When undefined: the port and register are absent and behaviour is otherwise identical.

Decomposition:
- Shared package josh_pkg holds:
  - the state encoding (S_MENU=0, S_ARM=1, S_PLAY=2, S_DEAD=3);
  - the gravity constants (GRAV_DOWN=0, GRAV_UP=1);
  - the default ROWS, DUDE_H and TICK_DIV values used by the screen updater and the wall generator.
- One sub-module, josh_tick_divider: a generalised parametrised rate counter with enable and wrap pulse, replacing the old sync_counter use.

Test Plan:
- Reset, then go high for 3 cycles and low -> state MENU->ARM->PLAY; in_game=1, player_y=20, score=0.
- TICK_DIV=4, all walls clear, grav=0, start at player_y=20 -> after 20 ticks player_y=0; it stays 0 and score keeps incrementing.
- Grounded at player_y=0, set grav=1 -> from the next tick player_y rises 1 per tick to ROWS-DUDE_H=114. Toggling grav mid-air does not reverse direction before landing.
- wall_ahead bit 22 set while player_y=20 -> endgame pulses exactly one cycle, in_game=0, score frozen; after 90 ticks state=MENU.
- wall_here bit 9 set with player at y=15 falling -> player lands and holds at y=10; score still increments.
- Force score to all-ones -> it saturates. With JOSH_HISCORE_EN: a game scoring 50 then one scoring 30 gives hiscore=50; resetn clears it to 0.
